load_store_unit: RTL and testbench

Core-side initiator for the byte-addressed data memory. It accepts one load or store request at a time from the execute stage and drives single-cycle read/write enable pulses with a size code onto the memory port. For loads it sign- or zero-extends the returned data. Sub-word stores are performed as a word read-modify-write, and the result goes back to writeback as a one-cycle response.

---
 rtl/load_store_unit.sv | 161 ++++++++++++++++
 tb/tb_load_store_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, single-cycle memory pulses, RMW for sub-word stores.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned requests respond with resp_err instead of being aligned.
module load_store_unit #(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_data_type,
  output logic        mem_read_en,
  output logic        mem_write_en,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, RESP} state_t;

  state_t      state_reg, state_next;
  logic        we_reg, uns_reg, resp_err_reg;
  logic [1:0]  size_reg, lane_reg, mem_type_reg;
  logic [15:0] wdata_reg;
  logic [3:0]  cnt_reg;
  logic [31:0] mem_addr_reg, mem_wdata_reg, resp_rdata_reg;

  logic        accept, trap, is_b, is_h, is_w;
  logic [1:0]  size_dec, type_dec;
  logic [31:0] eff_addr, load_ext, merged;

  // Size decode; funct3[1:0] of 10 or 11 is a word access (covers the undefined codes).
  assign is_b     = (req_funct3[1:0] == 2'b00);
  assign is_h     = (req_funct3[1:0] == 2'b01);
  assign is_w     = req_funct3[1];
  assign size_dec = is_b ? 2'b00 : (is_h ? 2'b01 : 2'b10);
  assign type_dec = is_b ? 2'b10 : (is_h ? 2'b01 : 2'b00);
  assign eff_addr = is_w ? {req_addr[31:2], 2'b00} :
                    is_h ? {req_addr[31:1], 1'b0}  : req_addr;
  assign accept   = req_valid && (state_reg == IDLE);

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = (is_h && req_addr[0]) || (is_w && (req_addr[1:0] != 2'b00));
`else
  assign trap = 1'b0;
`endif

  always_comb begin
    load_ext = mem_rdata;
    case (size_reg)
      2'b00:   load_ext = {{24{mem_rdata[7] & ~uns_reg}}, mem_rdata[7:0]};
      2'b01:   load_ext = {{16{mem_rdata[15] & ~uns_reg}}, mem_rdata[15:0]};
      default: load_ext = mem_rdata;
    endcase
  end

  // Sub-word store merge: each byte lane takes store data when addressed, else keeps the read word.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic       hit;
      logic [7:0] src;
      assign hit = (size_reg == 2'b00) ? (lane_reg == 2'(gi)) : (lane_reg[1] == 1'(gi / 2));
      assign src = (size_reg == 2'b00) ? wdata_reg[7:0] : wdata_reg[8*(gi%2) +: 8];
      assign merged[8*gi +: 8] = hit ? src : mem_rdata[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) begin
        if (trap)                state_next = RESP;
        else if (req_we && is_w) state_next = WR_ISSUE;
        else                     state_next = RD_ISSUE;
      end
      RD_ISSUE: state_next = RD_WAIT;
      RD_WAIT:  if (cnt_reg == 4'd1) state_next = we_reg ? WR_ISSUE : RESP;
      WR_ISSUE: state_next = RESP;
      RESP:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready    = (state_reg == IDLE);
    mem_read_en  = (state_reg == RD_ISSUE);
    mem_write_en = (state_reg == WR_ISSUE);
    resp_valid   = (state_reg == RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_reg         <= 1'b0;
      uns_reg        <= 1'b0;
      size_reg       <= 2'b00;
      lane_reg       <= 2'b00;
      wdata_reg      <= '0;
      cnt_reg        <= '0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      mem_type_reg   <= 2'b00;
      resp_rdata_reg <= '0;
      resp_err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (accept) begin
          we_reg    <= req_we;
          uns_reg   <= req_funct3[2];
          size_reg  <= size_dec;
          lane_reg  <= eff_addr[1:0];
          wdata_reg <= req_wdata[15:0];
          if (trap) begin
            resp_rdata_reg <= '0;
            resp_err_reg   <= 1'b1;
          end else begin
            mem_addr_reg <= (req_we && !is_w) ? {req_addr[31:2], 2'b00} : eff_addr;
            mem_type_reg <= req_we ? 2'b00 : type_dec;
            if (req_we && is_w) mem_wdata_reg <= req_wdata;
          end
        end
        RD_ISSUE: cnt_reg <= 4'(MEM_LAT);
        RD_WAIT: begin
          if (cnt_reg == 4'd1) begin
            cnt_reg <= '0;
            if (we_reg) mem_wdata_reg <= merged;
            else begin
              resp_rdata_reg <= load_ext;
              resp_err_reg   <= 1'b0;
            end
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        WR_ISSUE: begin
          resp_rdata_reg <= '0;
          resp_err_reg   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign mem_addr      = mem_addr_reg;
  assign mem_wdata     = mem_wdata_reg;
  assign mem_data_type = mem_type_reg;
  assign resp_rdata    = resp_rdata_reg;
  assign resp_err      = resp_err_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: latency-modelled memory plus a byte-level reference model.
module tb_load_store_unit;
  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_err, mem_read_en, mem_write_en;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  mem_data_type;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_data_type(mem_data_type),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en), .mem_rdata(mem_rdata)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory environment: word array, read returns the addressed lane zero-extended after LAT cycles.
  logic [31:0] mem [0:1023];
  logic [31:0] pipe_d [0:15];
  logic        pipe_v [0:15];
  logic [31:0] noise = '0;

  function automatic logic [31:0] rd_fn(input logic [31:0] a, input logic [1:0] t);
    logic [31:0] w;
    w = mem[a[11:2]];
    case (t)
      2'b10:   rd_fn = (w >> (8 * a[1:0])) & 32'h0000_00FF;
      2'b01:   rd_fn = (w >> (16 * a[1])) & 32'h0000_FFFF;
      default: rd_fn = w;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) pipe_v[i] <= 1'b0;
    end else begin
      for (int i = 15; i > 0; i--) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_d[i] <= pipe_d[i-1];
      end
      pipe_v[0] <= mem_read_en;
      pipe_d[0] <= rd_fn(mem_addr, mem_data_type);
      if (mem_write_en) mem[mem_addr[11:2]] = mem_wdata;
    end
  end

  always @(negedge clk) noise <= $urandom();
  assign mem_rdata = (pipe_v[LAT-1] === 1'b1) ? pipe_d[LAT-1] : noise;

  // Reference model: little-endian byte array.
  logic [7:0] ref_b [0:4095];

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [11:0] b;
    b = {a[11:2], 2'b00};
    ref_word = {ref_b[b+3], ref_b[b+2], ref_b[b+1], ref_b[b]};
  endfunction

  task automatic set_word(input logic [31:0] a, input logic [31:0] v);
    mem[a[11:2]] = v;
    for (int i = 0; i < 4; i++) ref_b[{a[11:2], 2'b00} + 12'(i)] = v[8*i +: 8];
  endtask

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    int sz, e_nrd, e_nwr, e_rdc, e_wrc, e_rspc, nrd, nwr, rdc, wrc, rspc, rdy_hi;
    logic mis, trap, e_err, g_err;
    logic [31:0] ea, e_rda, e_wra, e_wrd, e_data, v, g_rda, g_wra, g_wrd, g_data;
    logic [1:0] e_rdt, g_rdt;

    sz   = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    mis  = (a % sz) != 0;
    ea   = a - (a % sz);
`ifdef LSU_MISALIGN_TRAP_EN
    trap = mis;
`else
    trap = 1'b0;
`endif
    e_nrd = 0; e_nwr = 0; e_rdc = -1; e_wrc = -1; e_rda = '0; e_rdt = '0;
    e_wra = '0; e_wrd = '0; e_data = '0; e_err = 1'b0;
    if (trap) begin
      e_rspc = 1; e_err = 1'b1;
    end else if (!we) begin
      e_nrd = 1; e_rdc = 1; e_rda = ea;
      e_rdt = (sz == 1) ? 2'b10 : (sz == 2) ? 2'b01 : 2'b00;
      v = '0;
      for (int i = 0; i < sz; i++) v = v | (32'(ref_b[ea[11:0] + 12'(i)]) << (8 * i));
      if (f3 == 3'b000 && v[7])  v = v | 32'hFFFF_FF00;
      if (f3 == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
      e_data = v; e_rspc = LAT + 2;
    end else if (sz == 4) begin
      for (int i = 0; i < 4; i++) ref_b[ea[11:0] + 12'(i)] = wd[8*i +: 8];
      e_nwr = 1; e_wrc = 1; e_wra = ea; e_wrd = wd; e_rspc = 2;
    end else begin
      for (int i = 0; i < sz; i++) ref_b[ea[11:0] + 12'(i)] = wd[8*i +: 8];
      e_nrd = 1; e_rdc = 1; e_rda = {ea[31:2], 2'b00}; e_rdt = 2'b00;
      e_nwr = 1; e_wrc = LAT + 2; e_wra = {ea[31:2], 2'b00}; e_wrd = ref_word(ea);
      e_rspc = LAT + 3;
    end

    @(negedge clk);
    check_val("ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = $urandom_range(0, 1); req_funct3 = 3'($urandom());
    req_addr = $urandom(); req_wdata = $urandom();

    nrd = 0; nwr = 0; rdc = -1; wrc = -1; rspc = -1; rdy_hi = 0;
    g_rda = '0; g_rdt = '0; g_wra = '0; g_wrd = '0; g_data = '0; g_err = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (mem_read_en)  begin nrd++; rdc = k; g_rda = mem_addr; g_rdt = mem_data_type; end
      if (mem_write_en) begin nwr++; wrc = k; g_wra = mem_addr; g_wrd = mem_wdata; end
      if (req_ready) rdy_hi++;
      if (resp_valid) begin
        rspc = k; g_data = resp_rdata; g_err = resp_err;
        break;
      end
    end

    check_val("resp_cycle", 32'(rspc), 32'(e_rspc));
    check_val("busy_ready", 32'(rdy_hi), 32'd0);
    check_val("read_count", 32'(nrd), 32'(e_nrd));
    check_val("write_count", 32'(nwr), 32'(e_nwr));
    check_val("resp_err", 32'(g_err), 32'(e_err));
    check_val("resp_rdata", g_data, e_data);
    if (e_nrd == 1) begin
      check_val("read_cycle", 32'(rdc), 32'(e_rdc));
      check_val("read_addr", g_rda, e_rda);
      check_val("read_type", 32'(g_rdt), 32'(e_rdt));
    end
    if (e_nwr == 1) begin
      check_val("write_cycle", 32'(wrc), 32'(e_wrc));
      check_val("write_addr", g_wra, e_wra);
      check_val("write_data", g_wrd, e_wrd);
    end
    $display("txn we=%0d f3=%0d addr=%h wdata=%h -> rdata=%h err=%0d resp_at=%0d", we, f3, a, wd, g_data, g_err, rspc);
  endtask

  initial begin
    int nrd, rd1, rd2, nwr, bad;
    logic [2:0] st_f3 [0:5];
    logic [2:0] f3;
    logic we;

    st_f3[0] = 3'd0; st_f3[1] = 3'd1; st_f3[2] = 3'd2;
    st_f3[3] = 3'd3; st_f3[4] = 3'd6; st_f3[5] = 3'd7;
    for (int i = 0; i < 1024; i++) set_word(32'(i * 4), $urandom());

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_ready", 32'(req_ready), 32'd1);
    check_val("rst_outs", {27'd0, resp_valid, mem_read_en, mem_write_en, mem_data_type}, 32'd0);
    check_val("rst_addr", mem_addr, 32'd0);
    check_val("rst_rdata", resp_rdata, 32'd0);
    rst_n = 1'b1;

    set_word(32'h100, 32'h8899_AABB);
    do_req(1'b0, 3'b000, 32'h101, 32'h0);          // LB  -> FFFFFFAA
    do_req(1'b0, 3'b100, 32'h101, 32'h0);          // LBU -> 000000AA
    do_req(1'b1, 3'b010, 32'h200, 32'hDEAD_BEEF);  // SW
    do_req(1'b0, 3'b010, 32'h200, 32'h0);          // LW  -> DEADBEEF
    set_word(32'h300, 32'h1122_3344);
    do_req(1'b1, 3'b000, 32'h302, 32'h0000_0055);  // SB  -> 11553344
    do_req(1'b0, 3'b010, 32'h103, 32'h0);          // misaligned LW
    set_word(32'h100, 32'h8001_0000);
    do_req(1'b0, 3'b001, 32'h102, 32'h0);          // LH  -> FFFF8001
    do_req(1'b0, 3'b101, 32'h102, 32'h0);          // LHU -> 00008001
    do_req(1'b1, 3'b001, 32'h301, 32'hABCD_1234);  // misaligned SH
    do_req(1'b1, 3'b001, 32'h302, 32'h0000_9876);  // SH upper half

    for (int n = 0; n < 80; n++) begin
      we = 1'($urandom_range(0, 1));
      f3 = we ? st_f3[$urandom_range(0, 5)] : 3'($urandom_range(0, 7));
      do_req(we, f3, 32'($urandom_range(0, 1023)), $urandom());
    end

    // Reset in the middle of a byte store's read wait: no write may follow.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h300; req_wdata = 32'hEE;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("arst_ready", 32'(req_ready), 32'd1);
    check_val("arst_outs", {27'd0, resp_valid, mem_read_en, mem_write_en, mem_data_type}, 32'd0);
    check_val("arst_addr", mem_addr, 32'd0);
    check_val("arst_wdata", mem_wdata, 32'd0);
    check_val("arst_resp", {resp_rdata[30:0], resp_err}, 32'd0);
    nwr = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (mem_write_en) nwr++;
    end
    rst_n = 1'b1;
    for (int k = 0; k < LAT + 4; k++) begin
      @(negedge clk);
      if (mem_write_en) nwr++;
    end
    check_val("arst_no_write", 32'(nwr), 32'd0);
    do_req(1'b0, 3'b010, 32'h300, 32'h0);

    // req_valid held high: the second accept waits for the IDLE cycle after RESP.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h200;
    @(posedge clk);
    nrd = 0; rd1 = -1; rd2 = -1;
    for (int k = 1; k <= 2 * (LAT + 3); k++) begin
      @(negedge clk);
      if (mem_read_en) begin
        nrd++;
        if (rd1 < 0) rd1 = k; else rd2 = k;
      end
      if (k == 2 * (LAT + 3)) req_valid = 1'b0;
    end
    repeat (LAT + 4) @(negedge clk);
    check_val("b2b_reads", 32'(nrd), 32'd2);
    check_val("b2b_first", 32'(rd1), 32'd1);
    check_val("b2b_second", 32'(rd2), 32'(LAT + 4));

    bad = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_word(32'(i * 4))) bad++;
    check_val("mem_sweep", 32'(bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
